// File: rtl/kth_extreme_tracker.sv
// Streaming rank selector: keeps a sorted list of the K_MAX most extreme operands
// of a burst and reports entry[rank-1] (or an error flag) once the burst completes.
module kth_extreme_tracker #(
    parameter int DATA_W = 8,
    parameter int K_MAX  = 4,
    parameter int CNT_W  = 4,
    localparam int RANK_W = $clog2(K_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic [RANK_W-1:0] rank,
    input  logic              mode,
    input  logic              is_signed,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              error
);

    localparam int CMP_W = ((CNT_W > RANK_W) ? CNT_W : RANK_W) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    typedef logic [K_MAX-1:0][DATA_W-1:0] list_t;

    // Signed compare is an unsigned compare with the sign bits flipped.
    function automatic logic more_extreme(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic              min_mode,
                                          input logic              signed_cmp);
        logic [DATA_W-1:0] ax;
        logic [DATA_W-1:0] bx;
        ax = a ^ {signed_cmp, {(DATA_W-1){1'b0}}};
        bx = b ^ {signed_cmp, {(DATA_W-1){1'b0}}};
        if (min_mode) begin
            return ax < bx;
        end else begin
            return ax > bx;
        end
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RANK_W-1:0]  rank_q, rank_d;
    logic               mode_q, mode_d;
    logic               sgn_q, sgn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    list_t              ent_q, ent_d;
    logic [K_MAX-1:0]   occ_q, occ_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               rv_q, rv_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;

    logic [CNT_W:0]     cnt_inc_s;
    logic               last_s;
    logic [K_MAX-1:0]   ins_s;
    logic [K_MAX-1:0]   ins_prev_s;
    list_t              ent_sh_s;
    logic [K_MAX-1:0]   occ_sh_s;
    list_t              ent_ins_s;
    logic [K_MAX-1:0]   occ_ins_s;
    logic [DATA_W-1:0]  sel_s;
    logic               legal_s;
    logic [CMP_W-1:0]   rank_ext_s;
    logic [CMP_W-1:0]   count_ext_s;

    assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign last_s    = (cnt_inc_s == {1'b0, count_q});

    // Single-cycle insert: the slot list is a monotone mask, so the first set
    // bit takes data_in and every later set bit takes its upper neighbour.
    always_comb begin
        ent_sh_s   = {ent_q[K_MAX-2:0], {DATA_W{1'b0}}};
        occ_sh_s   = {occ_q[K_MAX-2:0], 1'b0};
        ins_s      = '0;
        ent_ins_s  = ent_q;
        occ_ins_s  = occ_q;
        for (int i = 0; i < K_MAX; i++) begin
            ins_s[i] = !occ_q[i] || more_extreme(data_in, ent_q[i], mode_q, sgn_q);
        end
        ins_prev_s = {ins_s[K_MAX-2:0], 1'b0};
        for (int i = 0; i < K_MAX; i++) begin
            if (!ins_s[i]) begin
                ent_ins_s[i] = ent_q[i];
                occ_ins_s[i] = occ_q[i];
            end else if (ins_prev_s[i]) begin
                ent_ins_s[i] = ent_sh_s[i];
                occ_ins_s[i] = occ_sh_s[i];
            end else begin
                ent_ins_s[i] = data_in;
                occ_ins_s[i] = 1'b1;
            end
        end
    end

    // Rank legality and entry selection from the latched burst settings.
    always_comb begin
        rank_ext_s  = CMP_W'(rank_q);
        count_ext_s = CMP_W'(count_q);
        legal_s     = (rank_q != {RANK_W{1'b0}}) && (rank_ext_s <= CMP_W'(K_MAX))
                      && (rank_ext_s <= count_ext_s);
        sel_s       = {DATA_W{1'b0}};
        for (int i = 0; i < K_MAX; i++) begin
            if (rank_q == RANK_W'(i + 1)) begin
                sel_s = ent_q[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (valid && last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst settings, keep-list and sample counter.
    always_comb begin
        count_d = count_q;
        rank_d  = rank_q;
        mode_d  = mode_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        ent_d   = ent_q;
        occ_d   = occ_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = count;
                    rank_d  = rank;
                    mode_d  = mode;
                    sgn_d   = is_signed;
                    cnt_d   = {CNT_W{1'b0}};
                    ent_d   = '0;
                    occ_d   = {K_MAX{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            COLLECT: begin
                if (valid) begin
                    ent_d = ent_ins_s;
                    occ_d = occ_ins_s;
                    cnt_d = cnt_inc_s[CNT_W-1:0];
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output logic; result and error hold between completions.
    always_comb begin
        result_d = result_q;
        error_d  = error_q;
        rv_d     = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_q)
            DONE: begin
                rv_d = 1'b1;
                if (legal_s) begin
                    result_d = sel_s;
                    error_d  = 1'b0;
                end else begin
                    result_d = {DATA_W{1'b0}};
                    error_d  = 1'b1;
                end
            end
            default: rv_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= {CNT_W{1'b0}};
            rank_q   <= {RANK_W{1'b0}};
            mode_q   <= 1'b0;
            sgn_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            ent_q    <= '0;
            occ_q    <= {K_MAX{1'b0}};
            result_q <= {DATA_W{1'b0}};
            rv_q     <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            rank_q   <= rank_d;
            mode_q   <= mode_d;
            sgn_q    <= sgn_d;
            cnt_q    <= cnt_d;
            ent_q    <= ent_d;
            occ_q    <= occ_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign error        = error_q;

endmodule
